fwd_network: RTL and testbench

Parametrised result-forwarding network for the dual-issue SPU pipeline; generalises the fixed seven-stage even/odd forwarding registers to LANES issue lanes and DEPTH stages. Each lane injects a result packet per cycle, packets shift toward writeback, and RD_PORTS operand-read ports are resolved each cycle with one of three outcomes:
- bypass data,
- register-file fall-through, or
- a hazard (stall request).

The block sits between issue/decode and the execution pipes and drives register-file writeback.

---
 rtl/fwd_network_pkg.sv | 34 +++
 rtl/fwd_network_if.sv | 41 ++++
 rtl/fwd_network_lookup.sv | 48 ++++
 rtl/fwd_network.sv | 144 ++++++++++++++
 tb/tb_fwd_network.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_network_pkg.sv
// Shared types and defaults for the result-forwarding network: the per-stage
// packet record, default geometry and small elaboration helpers.
package fwd_network_pkg;

  localparam int FWD_LANES_DEF = 2;
  localparam int FWD_DEPTH_DEF = 7;
  localparam int FWD_ADDR_W    = 7;
  localparam int FWD_LAT_W     = 3;
  localparam int LAT_W         = FWD_LAT_W;

  typedef struct packed {
    logic                  we;
    logic [FWD_ADDR_W-1:0] rt;
    logic [FWD_LAT_W-1:0]  lat;
  } fw_packet_t;

  // Latency 0 behaves as 1 and anything past the last stage behaves as the last stage.
  function automatic logic [FWD_LAT_W-1:0] clamp_lat(input logic [FWD_LAT_W-1:0] lat,
                                                     input int depth);
    logic [FWD_LAT_W-1:0] res;
    res = lat;
    if (lat == '0) begin
      res = FWD_LAT_W'(1);
    end else if (int'(lat) > depth) begin
      res = FWD_LAT_W'(depth);
    end
    return res;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fwd_network_if.sv
// Bundle of issue, lookup and writeback signals around the forwarding network.
// master = issue/execute side, slave = the network itself.
interface fwd_if #(
  parameter int LANES    = fwd_network_pkg::FWD_LANES_DEF,
  parameter int DEPTH    = fwd_network_pkg::FWD_DEPTH_DEF,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = fwd_network_pkg::FWD_ADDR_W,
  parameter int LAT_W    = fwd_network_pkg::FWD_LAT_W,
  parameter int RD_PORTS = 6
);

  logic [LANES-1:0]                         issue_valid;
  logic [LANES-1:0][ADDR_W-1:0]             issue_rt;
  logic [LANES-1:0][LAT_W-1:0]              issue_lat;
  logic [LANES-1:0][DEPTH-1:0][DATA_W-1:0]  stage_data;
  logic                                     flush;

  logic [RD_PORTS-1:0][ADDR_W-1:0]          rd_addr;
  logic [RD_PORTS-1:0]                      rd_hit;
  logic [RD_PORTS-1:0][DATA_W-1:0]          rd_data;
  logic [RD_PORTS-1:0]                      rd_hazard;
  logic                                     stall_req;

  logic [LANES-1:0]                         wb_en;
  logic [LANES-1:0][ADDR_W-1:0]             wb_rt;
  logic [LANES-1:0][DATA_W-1:0]             wb_data;
  logic                                     wb_conflict;

  modport master (
    output issue_valid, issue_rt, issue_lat, stage_data, flush, rd_addr,
    input  rd_hit, rd_data, rd_hazard, stall_req,
    input  wb_en, wb_rt, wb_data, wb_conflict
  );

  modport slave (
    input  issue_valid, issue_rt, issue_lat, stage_data, flush, rd_addr,
    output rd_hit, rd_data, rd_hazard, stall_req,
    output wb_en, wb_rt, wb_data, wb_conflict
  );

endinterface

// File: rtl/fwd_network_lookup.sv
// Youngest-match priority search for one operand-read port: lowest stage wins,
// and within a stage the highest (latest in program order) lane wins.
module fwd_lookup
  import fwd_network_pkg::*;
#(
  parameter int LANES = FWD_LANES_DEF,
  parameter int DEPTH = FWD_DEPTH_DEF,
  parameter int LW    = idx_w(LANES),
  parameter int SW    = idx_w(DEPTH)
) (
  input  fw_packet_t            pipe [LANES][DEPTH],
  input  logic [FWD_ADDR_W-1:0] rd_addr,
  output logic                  hit,
  output logic                  hazard,
  output logic [LW-1:0]         sel_lane,
  output logic [SW-1:0]         sel_stage
);

  logic                 found;
  logic [FWD_LAT_W-1:0] win_lat;
  logic                 ready;

  // NOTE: every variable written here gets a value before the search loop, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found     = 1'b0;
    win_lat   = '0;
    sel_lane  = '0;
    sel_stage = '0;
    // Scan oldest to youngest so the last match written is the winner.
    for (int s = DEPTH - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (pipe[l][s].we && (pipe[l][s].rt == rd_addr)) begin
          found     = 1'b1;
          win_lat   = pipe[l][s].lat;
          sel_lane  = LW'(l);
          sel_stage = SW'(s);
        end
      end
    end
  end

  // Array index s holds stage s+1.
  assign ready  = (int'(sel_stage) + 1) >= int'(win_lat);
  assign hit    = found && ready;
  assign hazard = found && !ready;

endmodule

// File: rtl/fwd_network.sv
// Parametrised result-forwarding network: per-lane packet shift pipes, per-port
// bypass lookup and writeback. Optional statistics counters under FWD_STATS_EN.
module fwd_network #(
  parameter int LANES       = fwd_network_pkg::FWD_LANES_DEF,
  parameter int DEPTH       = fwd_network_pkg::FWD_DEPTH_DEF,
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = fwd_network_pkg::FWD_ADDR_W,
  parameter int LAT_W       = fwd_network_pkg::FWD_LAT_W,
  parameter int RD_PORTS    = 6,
  parameter int FLUSH_STAGE = 2
) (
  input  logic        clock,
  input  logic        reset,
  fwd_if.slave        bus
`ifdef FWD_STATS_EN
  ,
  output logic [31:0] hazard_cycles,
  output logic [31:0] fwd_hits
`endif
);

  import fwd_network_pkg::*;

  localparam int LW = idx_w(LANES);
  localparam int SW = idx_w(DEPTH);

  fw_packet_t pipe_q [LANES][DEPTH];
  fw_packet_t pipe_d [LANES][DEPTH];

  logic [LANES-1:0][LAT_W-1:0] issue_lat;
  assign issue_lat = bus.issue_lat;

  // Flush squashes the issue packet and every packet leaving a stage below FLUSH_STAGE.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      pipe_d[l][0].we  = bus.issue_valid[l] && !bus.flush;
      pipe_d[l][0].rt  = FWD_ADDR_W'(bus.issue_rt[l]);
      pipe_d[l][0].lat = clamp_lat(FWD_LAT_W'(issue_lat[l]), DEPTH);
      for (int s = 1; s < DEPTH; s++) begin
        pipe_d[l][s] = pipe_q[l][s-1];
        if (bus.flush && (s < FLUSH_STAGE)) begin
          pipe_d[l][s].we = 1'b0;
        end
      end
    end
  end

  // NOTE: the packet array is a handful of flops, not a RAM, so it is cleared
  // by the asynchronous reset; state updates use non-blocking assignments so
  // every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < DEPTH; s++) begin
          pipe_q[l][s] <= '0;
        end
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  logic [RD_PORTS-1:0] hit_w;
  logic [RD_PORTS-1:0] haz_w;
  logic [LW-1:0]       sel_lane  [RD_PORTS];
  logic [SW-1:0]       sel_stage [RD_PORTS];

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    fwd_lookup #(
      .LANES (LANES),
      .DEPTH (DEPTH),
      .LW    (LW),
      .SW    (SW)
    ) u_lookup (
      .pipe      (pipe_q),
      .rd_addr   (FWD_ADDR_W'(bus.rd_addr[p])),
      .hit       (hit_w[p]),
      .hazard    (haz_w[p]),
      .sel_lane  (sel_lane[p]),
      .sel_stage (sel_stage[p])
    );
  end

  assign bus.rd_hit    = hit_w;
  assign bus.rd_hazard = haz_w;
  assign bus.stall_req = |haz_w;

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      bus.rd_data[p] = {DATA_W{1'b0}};
      if (hit_w[p]) begin
        bus.rd_data[p] = bus.stage_data[sel_lane[p]][sel_stage[p]];
      end
    end
  end

  // Data is gated by the enable so an idle writeback port reads as zero.
  always_comb begin
    bus.wb_conflict = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      bus.wb_en[l]   = pipe_q[l][DEPTH-1].we;
      bus.wb_rt[l]   = ADDR_W'(pipe_q[l][DEPTH-1].rt);
      bus.wb_data[l] = pipe_q[l][DEPTH-1].we ? bus.stage_data[l][DEPTH-1] : {DATA_W{1'b0}};
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (pipe_q[i][DEPTH-1].we && pipe_q[j][DEPTH-1].we &&
            (pipe_q[i][DEPTH-1].rt == pipe_q[j][DEPTH-1].rt)) begin
          bus.wb_conflict = 1'b1;
        end
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] hazard_cycles_q, hazard_cycles_d;
  logic [31:0] fwd_hits_q, fwd_hits_d;

  always_comb begin
    hazard_cycles_d = hazard_cycles_q;
    fwd_hits_d      = fwd_hits_q;
    if ((|haz_w) && (hazard_cycles_q != '1)) begin
      hazard_cycles_d = hazard_cycles_q + 32'd1;
    end
    if ((|hit_w) && (fwd_hits_q != '1)) begin
      fwd_hits_d = fwd_hits_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hazard_cycles_q <= '0;
      fwd_hits_q      <= '0;
    end else begin
      hazard_cycles_q <= hazard_cycles_d;
      fwd_hits_q      <= fwd_hits_d;
    end
  end

  assign hazard_cycles = hazard_cycles_q;
  assign fwd_hits      = fwd_hits_q;
`endif

endmodule

// File: tb/tb_fwd_network.sv
// Directed bench for fwd_network: a per-cycle vector table for bypass/hazard/
// writeback, then hand sequences for flush, mid-flight reset and streaming.
module tb_fwd_network;

  localparam int LANES    = 2;
  localparam int DEPTH    = 7;
  localparam int DATA_W   = 128;
  localparam int ADDR_W   = 7;
  localparam int LAT_W    = 3;
  localparam int RD_PORTS = 6;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fwd_if #(
    .LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .LAT_W(LAT_W), .RD_PORTS(RD_PORTS)
  ) bus ();

`ifdef FWD_STATS_EN
  logic [31:0] hazard_cycles;
  logic [31:0] fwd_hits;
`endif

  fwd_network #(
    .LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .LAT_W(LAT_W), .RD_PORTS(RD_PORTS), .FLUSH_STAGE(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FWD_STATS_EN
    ,
    .hazard_cycles (hazard_cycles),
    .fwd_hits      (fwd_hits)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [1:0] iv;
    logic [6:0] rt0;
    logic [2:0] lat0;
    logic [6:0] rt1;
    logic [2:0] lat1;
    logic [6:0] ra;
    logic       e_hit;
    logic       e_haz;
    int         e_lane;
    int         e_idx;
    logic [1:0] e_wb_en;
    logic [6:0] e_wb_rt0;
    logic       e_conf;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input string name, input int iv, input int rt0, input int lat0,
                              input int rt1, input int lat1, input int ra, input int e_hit,
                              input int e_haz, input int e_lane, input int e_idx,
                              input int e_wb_en, input int e_wb_rt0, input int e_conf);
    vec_t v;
    v.name     = name;
    v.iv       = 2'(iv);
    v.rt0      = 7'(rt0);
    v.lat0     = 3'(lat0);
    v.rt1      = 7'(rt1);
    v.lat1     = 3'(lat1);
    v.ra       = 7'(ra);
    v.e_hit    = 1'(e_hit);
    v.e_haz    = 1'(e_haz);
    v.e_lane   = e_lane;
    v.e_idx    = e_idx;
    v.e_wb_en  = 2'(e_wb_en);
    v.e_wb_rt0 = 7'(e_wb_rt0);
    v.e_conf   = 1'(e_conf);
    return v;
  endfunction

  // Stage data pattern; s is the 0-based index of stage s+1.
  function automatic logic [127:0] sd(input int l, input int s);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ 32'(l * 256 + s + 1);
    return {4{w}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_issue(input logic [1:0] iv, input int rt0, input int lat0,
                           input int rt1, input int lat1, input logic fl);
    bus.issue_valid  = iv;
    bus.issue_rt[0]  = 7'(rt0);
    bus.issue_lat[0] = 3'(lat0);
    bus.issue_rt[1]  = 7'(rt1);
    bus.issue_lat[1] = 3'(lat1);
    bus.flush        = fl;
  endtask

  task automatic set_ra(input int a);
    for (int p = 0; p < RD_PORTS; p++) bus.rd_addr[p] = 7'(a);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    set_issue(2'b00, 0, 0, 0, 0, 1'b0);
    set_ra(0);
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < DEPTH; s++) bus.stage_data[l][s] = sd(l, s);

    // Reset state: every output reads zero even though stage_data is live.
    #3;
    check("rst rd_hit",      128'(bus.rd_hit),      128'(0));
    check("rst rd_hazard",   128'(bus.rd_hazard),   128'(0));
    check("rst stall_req",   128'(bus.stall_req),   128'(0));
    check("rst rd_data0",    bus.rd_data[0],        128'(0));
    check("rst wb_en",       128'(bus.wb_en),       128'(0));
    check("rst wb_rt",       128'(bus.wb_rt),       128'(0));
    check("rst wb_data0",    bus.wb_data[0],        128'(0));
    check("rst wb_data1",    bus.wb_data[1],        128'(0));
    check("rst wb_conflict", 128'(bus.wb_conflict), 128'(0));
    #9;
    reset = 1'b1;
    tick();

    //            name   iv rt0 lat0 rt1 lat1 ra hit haz lane idx wb_en wb_rt0 conf
    tbl[0]  = mk("r0",   1, 5,  2,   0,  0,   5, 0,  0,  0,   0,  0,    0,     0);
    tbl[1]  = mk("r1",   0, 0,  0,   0,  0,   5, 0,  1,  0,   0,  0,    0,     0);
    tbl[2]  = mk("r2",   0, 0,  0,   0,  0,   5, 1,  0,  0,   1,  0,    0,     0);
    tbl[3]  = mk("r3",   3, 9,  1,   9,  1,   9, 0,  0,  0,   0,  0,    0,     0);
    tbl[4]  = mk("r4",   0, 0,  0,   0,  0,   9, 1,  0,  1,   0,  0,    0,     0);
    tbl[5]  = mk("r5",   1, 3,  0,   0,  0,   9, 1,  0,  1,   1,  0,    0,     0);
    tbl[6]  = mk("r6",   0, 0,  0,   0,  0,   3, 1,  0,  0,   0,  0,    0,     0);
    tbl[7]  = mk("r7",   1, 3,  6,   0,  0,   3, 1,  0,  0,   1,  1,    5,     0);
    tbl[8]  = mk("r8",   0, 0,  0,   0,  0,   3, 0,  1,  0,   0,  0,    0,     0);
    tbl[9]  = mk("r9",   0, 0,  0,   0,  0,   5, 0,  0,  0,   0,  0,    0,     0);
    tbl[10] = mk("r10",  0, 0,  0,   0,  0,   9, 1,  0,  1,   6,  3,    9,     1);
    tbl[11] = mk("r11",  0, 0,  0,   0,  0,   3, 0,  1,  0,   0,  0,    0,     0);
    tbl[12] = mk("r12",  0, 0,  0,   0,  0,   3, 0,  1,  0,   0,  1,    3,     0);
    tbl[13] = mk("r13",  0, 0,  0,   0,  0,   3, 1,  0,  0,   5,  0,    0,     0);
    tbl[14] = mk("r14",  0, 0,  0,   0,  0,   3, 1,  0,  0,   6,  1,    3,     0);
    tbl[15] = mk("r15",  0, 0,  0,   0,  0,   3, 0,  0,  0,   0,  0,    0,     0);

    for (int i = 0; i < 16; i++) begin
      logic [127:0] exp_data;
      set_issue(tbl[i].iv, int'(tbl[i].rt0), int'(tbl[i].lat0),
                int'(tbl[i].rt1), int'(tbl[i].lat1), 1'b0);
      set_ra(int'(tbl[i].ra));
      #2;
      exp_data = tbl[i].e_hit ? sd(tbl[i].e_lane, tbl[i].e_idx) : 128'(0);
      check($sformatf("%s rd_hit", tbl[i].name), 128'(bus.rd_hit), 128'({RD_PORTS{tbl[i].e_hit}}));
      check($sformatf("%s rd_hazard", tbl[i].name), 128'(bus.rd_hazard), 128'({RD_PORTS{tbl[i].e_haz}}));
      check($sformatf("%s rd_data0", tbl[i].name), bus.rd_data[0], exp_data);
      check($sformatf("%s rd_data5", tbl[i].name), bus.rd_data[RD_PORTS-1], exp_data);
      check($sformatf("%s stall_req", tbl[i].name), 128'(bus.stall_req), 128'(tbl[i].e_haz));
      check($sformatf("%s wb_en", tbl[i].name), 128'(bus.wb_en), 128'(tbl[i].e_wb_en));
      check($sformatf("%s wb_conflict", tbl[i].name), 128'(bus.wb_conflict), 128'(tbl[i].e_conf));
      check($sformatf("%s wb_data0", tbl[i].name), bus.wb_data[0],
            tbl[i].e_wb_en[0] ? sd(0, DEPTH - 1) : 128'(0));
      check($sformatf("%s wb_data1", tbl[i].name), bus.wb_data[1],
            tbl[i].e_wb_en[1] ? sd(1, DEPTH - 1) : 128'(0));
      if (tbl[i].e_wb_en[0])
        check($sformatf("%s wb_rt0", tbl[i].name), 128'(bus.wb_rt[0]), 128'(tbl[i].e_wb_rt0));
      tick();
    end

    // Flush with packets at stage 1 (rt 21) and stage 3 (rt 20), plus a squashed issue (rt 22).
    set_issue(2'b01, 20, 7, 0, 0, 1'b0); tick();
    set_issue(2'b00, 0, 0, 0, 0, 1'b0);  tick();
    set_issue(2'b01, 21, 7, 0, 0, 1'b0); tick();
    set_issue(2'b01, 22, 7, 0, 0, 1'b1);
    set_ra(20);
    #2;
    check("flush pre stage3 hazard", 128'(bus.rd_hazard[0]), 128'(1));
    tick();
    set_issue(2'b00, 0, 0, 0, 0, 1'b0);
    set_ra(21);
    bus.rd_addr[1] = 7'd22;
    for (int c = 4; c < 12; c++) begin
      #2;
      if (c == 4) begin
        check("flush squashed hit",    128'(bus.rd_hit),    128'(0));
        check("flush squashed hazard", 128'(bus.rd_hazard), 128'(0));
      end
      check($sformatf("flush c%0d wb_en", c), 128'(bus.wb_en), (c == 7) ? 128'(1) : 128'(0));
      if (c == 7) check("flush survivor wb_rt", 128'(bus.wb_rt[0]), 128'(20));
      tick();
    end

    // Reset while four packets are in flight.
    for (int k = 0; k < 4; k++) begin
      set_issue(2'b01, 30 + k, 1, 0, 0, 1'b0);
      tick();
    end
    set_issue(2'b00, 0, 0, 0, 0, 1'b0);
    set_ra(33);
    #2;
    check("pre-reset hit", 128'(bus.rd_hit[0]), 128'(1));
    reset = 1'b0;
    #1;
    check("async rst rd_hit",    128'(bus.rd_hit),    128'(0));
    check("async rst rd_hazard", 128'(bus.rd_hazard), 128'(0));
    check("async rst stall_req", 128'(bus.stall_req), 128'(0));
    check("async rst wb_en",     128'(bus.wb_en),     128'(0));
    check("async rst wb_data0",  bus.wb_data[0],      128'(0));
    tick();
    reset = 1'b1;
    set_ra(30);
    for (int c = 0; c < 10; c++) begin
      #2;
      check($sformatf("post-rst c%0d wb_en", c), 128'(bus.wb_en), 128'(0));
      tick();
    end
    set_issue(2'b01, 40, 1, 0, 0, 1'b0);
    tick();
    set_issue(2'b00, 0, 0, 0, 0, 1'b0);
    set_ra(40);
    #2;
    check("first issue after rst hit",  128'(bus.rd_hit[0]), 128'(1));
    check("first issue after rst data", bus.rd_data[0],      sd(0, 0));
    for (int c = 0; c < 8; c++) tick();

    // Ten back-to-back packets rt 1..10, lat 7: writeback streams from cycle 7.
    set_ra(0);
    for (int c = 0; c < 18; c++) begin
      if (c < 10) set_issue(2'b01, c + 1, 7, 0, 0, 1'b0);
      else        set_issue(2'b00, 0, 0, 0, 0, 1'b0);
      #2;
      check($sformatf("stream c%0d wb_en", c), 128'(bus.wb_en[0]),
            (c >= 7 && c <= 16) ? 128'(1) : 128'(0));
      if (c >= 7 && c <= 16) begin
        check($sformatf("stream c%0d wb_rt", c), 128'(bus.wb_rt[0]), 128'(c - 6));
        check($sformatf("stream c%0d wb_data", c), bus.wb_data[0], sd(0, DEPTH - 1));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
